bram16_dma: RTL

//  Initiator/master for the 16-bit word memory port: drives address, write data and write enable,
//  and consumes the registered read data (1-cycle latency). Copies a block of len words

---
 rtl/bram16_dma_pkg.sv | 15 +
 rtl/bram16_dma_if.sv | 15 +
 rtl/bram16_dma_ctr.sv | 32 +++
 rtl/bram16_dma.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/bram16_dma_pkg.sv
// Shared definitions for the bram16 block-copy DMA: FSM encodings and data width.
package bram16_dma_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_FILL = 3'd4,
    S_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/bram16_dma_if.sv
// Single-port BRAM bus: the DMA is the master, the memory is the slave.
// mem_di is registered read data, valid the cycle after mem_a.
interface bram16_dma_if
  import bram16_dma_pkg::*;
#(
  parameter int ADR_W = 16
);
  logic [ADR_W-1:0]  mem_a;
  logic [DATA_W-1:0] mem_do;
  logic              mem_we;
  logic [DATA_W-1:0] mem_di;

  modport master (output mem_a, output mem_do, output mem_we, input  mem_di);
  modport slave  (input  mem_a, input  mem_do, input  mem_we, output mem_di);
endinterface

// File: rtl/bram16_dma_ctr.sv
// Loadable incrementing address register; wraps modulo 2^W.
// nxt exposes the value the register takes at the next edge so the
// parent can register its memory address output from it.
module bram16_dma_ctr #(
  parameter int W = 16
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] q,
  output logic [W-1:0] nxt
);
  logic [W-1:0] cnt_q, cnt_d;

  // load has priority over increment
  always_comb begin
    cnt_d = cnt_q;
    if (load)     cnt_d = ld_val;
    else if (inc) cnt_d = cnt_q + W'(1);
  end

  // address register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign q   = cnt_q;
  assign nxt = cnt_d;
endmodule

// File: rtl/bram16_dma.sv
// Block-copy DMA on one BRAM port: RD -> CAP -> WR per word, ascending.
// Optional fill mode (macro BRAM16_DMA_FILL_EN) writes a constant pattern
// at one word per cycle.
// Memory-side outputs are registered from next-state values; only mem_we is
// additionally gated by abort so a write in the abort cycle never lands.
module bram16_dma
  import bram16_dma_pkg::*;
#(
  parameter int adr_width = 16,
  parameter int len_width = 10
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [adr_width-1:0] src,
  input  logic [adr_width-1:0] dst,
  input  logic [len_width-1:0] len,
  input  logic                 fill,
  input  logic [DATA_W-1:0]    pattern,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  bram16_dma_if.master         mem
);
  state_e                 state_q, state_d;
  logic [len_width-1:0]   rem_q, rem_d;
  logic                   aborted_q, aborted_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [adr_width-1:0]   mem_a_q, mem_a_d;
  logic [DATA_W-1:0]      mem_do_q, mem_do_d;
  logic                   mem_we_q, mem_we_d;
  logic                   ld, inc;
  logic [adr_width-1:0]   src_cur, src_nxt, dst_cur, dst_nxt;
  logic [DATA_W-1:0]      pat_nxt;

`ifdef BRAM16_DMA_FILL_EN
  logic [DATA_W-1:0]      pattern_q, pattern_d;

  // fill pattern latched on an accepted start
  always_comb begin
    pattern_d = pattern_q;
    if (ld) pattern_d = pattern;
  end

  // pattern register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) pattern_q <= '0;
    else            pattern_q <= pattern_d;
  end

  assign pat_nxt = pattern_d;
`else
  logic unused_fill;
  assign unused_fill = ^{fill, pattern};
  assign pat_nxt     = '0;
`endif

  bram16_dma_ctr #(.W(adr_width)) u_src (
    .sys_clk, .sys_rst_n, .load(ld), .inc, .ld_val(src), .q(src_cur), .nxt(src_nxt)
  );
  bram16_dma_ctr #(.W(adr_width)) u_dst (
    .sys_clk, .sys_rst_n, .load(ld), .inc, .ld_val(dst), .q(dst_cur), .nxt(dst_nxt)
  );

  // next-state, word count and abort tracking
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    aborted_d = aborted_q;
    ld        = 1'b0;
    inc       = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        ld        = 1'b1;
        rem_d     = len;
        aborted_d = 1'b0;
        if (len == '0) state_d = S_DONE;
`ifdef BRAM16_DMA_FILL_EN
        else if (fill) state_d = S_FILL;
`endif
        else           state_d = S_RD;
      end
      S_RD:  state_d = S_CAP;
      S_CAP: state_d = S_WR;
      S_WR: begin
        inc     = 1'b1;
        rem_d   = rem_q - len_width'(1);
        state_d = (rem_q == len_width'(1)) ? S_DONE : S_RD;
      end
`ifdef BRAM16_DMA_FILL_EN
      S_FILL: begin
        inc     = 1'b1;
        rem_d   = rem_q - len_width'(1);
        state_d = (rem_q == len_width'(1)) ? S_DONE : S_FILL;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE && state_q != S_DONE) begin
      state_d   = S_DONE;
      aborted_d = 1'b1;
    end
  end

  // registered outputs, derived from the state being entered
  always_comb begin
    mem_a_d  = mem_a_q;
    mem_do_d = mem_do_q;
    mem_we_d = 1'b0;
    unique case (state_d)
      S_RD: mem_a_d = src_nxt;
      S_WR: begin
        mem_a_d  = dst_nxt;
        mem_do_d = mem.mem_di;   // state_q is CAP: read data valid now
        mem_we_d = 1'b1;
      end
      S_FILL: begin
        mem_a_d  = dst_nxt;
        mem_do_d = pat_nxt;
        mem_we_d = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE) || (state_q != S_IDLE);
    done_d = (state_q == S_DONE);
  end

  // state and output registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mem_a_q   <= '0;
      mem_do_q  <= '0;
      mem_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      aborted_q <= aborted_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mem_a_q   <= mem_a_d;
      mem_do_q  <= mem_do_d;
      mem_we_q  <= mem_we_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign mem.mem_a  = mem_a_q;
  assign mem.mem_do = mem_do_q;
  assign mem.mem_we = mem_we_q & ~abort;
endmodule
